// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit start validation, LSB-first data
// sampling at bit centres, stop-bit check and a ready/read byte handshake.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   rx_input       asynchronous serial line, idle high
//   rx_data        last correctly framed byte
//   rx_ready       high while rx_data holds an unread byte
//   rx_read        consumer acknowledge, single-cycle pulse
//   rx_busy        high whenever the receiver is not idle
//   rx_frame_error one-cycle pulse when the stop bit is sampled low
//   rx_overrun     sticky: a byte was overwritten before being read
module uart_rx #(
  parameter int CLK_IN      = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int BIT_CYCLES  = (CLK_IN + BAUD_RATE / 2) / BAUD_RATE,
  parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_input,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_read,
  output logic       rx_busy,
  output logic       rx_frame_error,
  output logic       rx_overrun
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          load;
  logic          rxs;

  assign rxs = sync2_q;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_input;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    load    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          // Shift in at the MSB so the first bit received lands in bit 0.
          shift_d = {rxs, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            load    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold off start detection until the line has returned high.
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output handshake: a load on the same edge as a read wins and is not
  // counted as an overrun.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    if (load) begin
      data_d  = shift_q;
      ready_d = 1'b1;
    end else if (rx_read) begin
      ready_d = 1'b0;
    end
    if (load && ready_q && !rx_read) ovr_d = 1'b1;
    else if (rx_read)                ovr_d = 1'b0;
  end

  assign rx_data        = data_q;
  assign rx_ready       = ready_q;
  assign rx_busy        = (state_q != S_IDLE);
  assign rx_frame_error = ferr_q;
  assign rx_overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at default parameters
// (104 clocks per bit, 52 to the start-bit centre).
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       rx_input;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_read;
  logic       rx_busy;
  logic       rx_frame_error;
  logic       rx_overrun;

  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good;

  typedef struct {
    logic [7:0] data;
    logic       read_after;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl[4];

  uart_rx #(
    .CLK_IN(12000000),
    .BAUD_RATE(115200)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_input(rx_input),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .rx_read(rx_read),
    .rx_busy(rx_busy),
    .rx_frame_error(rx_frame_error),
    .rx_overrun(rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rx_frame_error) ferr_seen++;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one 8N1 frame starting at the current negedge. A non-zero
  // abort_at releases the line high after that many clocks and returns.
  task automatic drive_frame(input logic [7:0] d, input logic stop,
                             input int bitcyc, input int abort_at);
    logic [9:0] bits;
    int n;
    bits = {stop, d, 1'b0};
    n = 0;
    if (stop && abort_at == 0) exp_q.push_back(d);
    for (int b = 0; b < 10; b++) begin
      rx_input = bits[b];
      for (int c = 0; c < bitcyc; c++) begin
        if (abort_at > 0 && n == abort_at) begin
          rx_input = 1'b1;
          return;
        end
        @(negedge clk);
        n++;
      end
    end
    if (stop) rx_input = 1'b1;
  endtask

  task automatic check_rx(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0x%0h expected a queued byte", name, rx_data);
    end else begin
      e = exp_q.pop_front();
      check({name, "_data"}, 32'(rx_data), 32'(e));
      check({name, "_ready"}, 32'(rx_ready), 32'd1);
      last_good = e;
    end
  endtask

  task automatic pulse_read();
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int f0;
    tbl[0] = '{data: 8'hA5, read_after: 1'b1, exp_ovr: 1'b0};
    tbl[1] = '{data: 8'h01, read_after: 1'b1, exp_ovr: 1'b0};
    tbl[2] = '{data: 8'h11, read_after: 1'b0, exp_ovr: 1'b0};
    tbl[3] = '{data: 8'h22, read_after: 1'b1, exp_ovr: 1'b1};

    reset = 1'b1;
    rx_input = 1'b1;
    rx_read = 1'b0;
    last_good = 8'h00;
    #2;
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_ferr", 32'(rx_frame_error), 32'd0);
    check("rst_ovr", 32'(rx_overrun), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Good frames, with and without acknowledge (last two form the overrun case).
    for (int i = 0; i < 4; i++) begin
      f0 = ferr_seen;
      drive_frame(tbl[i].data, 1'b1, 104, 0);
      check_rx("tbl");
      check("tbl_ovr", 32'(rx_overrun), 32'(tbl[i].exp_ovr));
      check("tbl_ferr", 32'(ferr_seen - f0), 32'd0);
      if (tbl[i].read_after) begin
        pulse_read();
        check("tbl_ready_after_read", 32'(rx_ready), 32'd0);
        check("tbl_ovr_after_read", 32'(rx_overrun), 32'd0);
        check("tbl_busy_after_read", 32'(rx_busy), 32'd0);
      end
    end

    // Short low glitch must be rejected at the start-bit centre.
    f0 = ferr_seen;
    rx_input = 1'b0;
    repeat (20) @(negedge clk);
    rx_input = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_busy", 32'(rx_busy), 32'd0);
    check("glitch_ready", 32'(rx_ready), 32'd0);
    check("glitch_data", 32'(rx_data), 32'(last_good));
    check("glitch_ferr", 32'(ferr_seen - f0), 32'd0);
    drive_frame(8'h3C, 1'b1, 104, 0);
    check_rx("glitch_next");
    pulse_read();

    // Low stop bit followed by a held-low line.
    f0 = ferr_seen;
    drive_frame(8'h3C, 1'b0, 104, 0);
    repeat (300) @(negedge clk);
    check("break_ferr_pulses", 32'(ferr_seen - f0), 32'd1);
    check("break_ready", 32'(rx_ready), 32'd0);
    check("break_data", 32'(rx_data), 32'(last_good));
    check("break_busy", 32'(rx_busy), 32'd1);
    rx_input = 1'b1;
    repeat (5) @(negedge clk);
    check("break_busy_released", 32'(rx_busy), 32'd0);
    drive_frame(8'h81, 1'b1, 104, 0);
    check_rx("break_next");
    pulse_read();

    // Read coinciding with a load: the load wins, no overrun.
    drive_frame(8'h00, 1'b1, 104, 0);
    check_rx("coinc_first");
    check("coinc_first_ovr", 32'(rx_overrun), 32'd0);
    // The stop-bit sample lands on the 991st rising edge after the start
    // bit is driven (2 synchroniser edges + 1 detect + 52 + 9*104).
    fork
      drive_frame(8'hFF, 1'b1, 104, 0);
      begin
        repeat (990) @(negedge clk);
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
      end
    join
    check_rx("coinc_second");
    check("coinc_ovr", 32'(rx_overrun), 32'd0);

    // Reset in the middle of data bit 4, with an unread byte pending.
    drive_frame(8'h5A, 1'b1, 104, 570);
    reset = 1'b1;
    #1;
    check("midrst_data", 32'(rx_data), 32'h00);
    check("midrst_ready", 32'(rx_ready), 32'd0);
    check("midrst_busy", 32'(rx_busy), 32'd0);
    check("midrst_ferr", 32'(rx_frame_error), 32'd0);
    check("midrst_ovr", 32'(rx_overrun), 32'd0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    repeat (1200) @(negedge clk);
    check("midrst_no_partial", 32'(rx_ready), 32'd0);
    check("midrst_idle", 32'(rx_busy), 32'd0);
    drive_frame(8'h5A, 1'b1, 100, 0);
    check_rx("slow_baud");
    check("slow_baud_ovr", 32'(rx_overrun), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's uart_2 transmitter, using the same CLK_IN/BAUD_RATE parameters.
- Synchronises the asynchronous serial line and validates the start bit at mid-bit.
- Samples 8 data bits LSB-first at bit centres, checks the stop bit, and presents the byte through a ready/read handshake with framing-error and overrun reporting.
- Sits between the board RX pin and whatever consumes bytes, e.g. a command parser or FIFO.

Parameters:
- CLK_IN, 12000000, input clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate in baud.
- BIT_CYCLES, (CLK_IN + BAUD_RATE/2)/BAUD_RATE (=104 at defaults), clocks per bit, rounded to nearest.
- HALF_CYCLES, BIT_CYCLES/2 (=52), clocks from start-edge detection to the start-bit centre.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- rx_input  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last correctly framed byte.
- rx_ready  output  1  high while rx_data holds an unread byte.
- rx_read  input  1  consumer acknowledge; single-cycle pulse.
- rx_busy  output  1  high in every state except IDLE.
- rx_frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- rx_overrun  output  1  sticky flag: a byte was overwritten before it was read.

Behaviour:
- Reset values:
  - rx_data=0x00; rx_ready=0; rx_busy=0; rx_frame_error=0; rx_overrun=0.
  - Synchroniser flops=1; state=IDLE; counters=0.
- Synchroniser: two flops on rx_input; all decisions use the second-stage output (rxs). Adds 2 cycles of latency.
- One cycle counter (width ≥ clog2(BIT_CYCLES)) and one 3-bit bit index. The counter resets to 0 on every state entry and after every sample.
- States:
  - IDLE: rxs==0 -> START, cnt=0.
  - START: when cnt==HALF_CYCLES-1, sample rxs.
    - 1 -> IDLE (glitch rejected, no flags).
    - 0 -> DATA, idx=0.
  - DATA: when cnt==BIT_CYCLES-1, shift rxs into the shift register MSB so the first bit ends up in bit 0 (LSB-first). If idx==7 -> STOP, else idx+1.
  - STOP: when cnt==BIT_CYCLES-1, sample rxs.
    - 1 -> load rx_data from the shift register, set rx_ready, go to IDLE.
    - 0 -> pulse rx_frame_error for 1 cycle, leave rx_data/rx_ready unchanged, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. This blocks a false start detection during a break or a stuck-low line.
- Timing:
  - Stop-bit sample at HALF_CYCLES + 9*BIT_CYCLES cycles after IDLE sees rxs low.
  - rx_ready and rx_data update on the same edge as the stop-bit sample.
- Handshake:
  - rx_read while rx_ready=1 clears rx_ready on the next edge.
  - rx_read while rx_ready=0 is ignored.
- Simultaneous load and read on the same edge: the load wins. rx_ready stays 1, rx_data takes the new byte, rx_overrun is not set.
- Overrun: a load with rx_ready=1 and rx_read=0 overwrites rx_data and sets rx_overrun. rx_overrun clears on any rx_read edge where no new overrun occurs.
- Back-to-back frames: after a good stop bit the block is in IDLE and detects the next start edge immediately. No idle bit is required beyond the stop bit.
- Reset mid-frame (any state): all outputs go to reset values without a clock. The partial byte is discarded and never presented. The first frame after reset release is received normally.
- The receiver tolerates ±4% baud mismatch. Sampling is at bit centres with no resynchronisation after the start edge.

Test Plan:
1. Defaults, drive 8N1 frame 0xA5 at 104 cycles/bit -> rx_ready=1, rx_data=0xA5, frame_error=0, overrun=0; pulse rx_read -> rx_ready=0 next cycle, rx_busy=0.
2. Low glitch of 20 cycles on an idle line -> START aborts to IDLE; rx_ready, rx_frame_error, rx_data unchanged; a following 0x3C frame is received correctly.
3. Frame 0x3C with stop bit driven low, line held low 300 cycles then high -> one-cycle rx_frame_error, rx_ready=0, rx_busy=1 until the line returns high; next 0x81 frame received.
4. Frames 0x11 then 0x22 back-to-back with no rx_read -> rx_data=0x22, rx_ready=1, rx_overrun=1; rx_read -> both cleared.
5. Frames 0x00 then 0xFF, rx_read asserted on the exact edge the 0xFF loads -> rx_ready stays 1, rx_data=0xFF, rx_overrun=0.
6. Assert reset during data bit 4 of 0x5A, release after 10 cycles -> outputs at reset values during reset, no partial byte presented; next 0x5A frame at 100 cycles/bit (−4%) received correctly.
